// File: rtl/wdt_pkg.sv
// Shared types and register map for the watchdog timeout generator.
package wdt_pkg;

  typedef enum logic [1:0] {
    WDT_IDLE    = 2'd0,
    WDT_COUNT   = 2'd1,
    WDT_EXPIRED = 2'd2
  } wdt_state_e;

  localparam logic [1:0] WDT_ADDR_WDEN   = 2'd0;
  localparam logic [1:0] WDT_ADDR_WDLIVE = 2'd1;
  localparam logic [1:0] WDT_ADDR_WTOCNT = 2'd2;
  localparam logic [1:0] WDT_ADDR_STATUS = 2'd3;

  // Wide enough for any supported CNT_W; sliced down at the point of use.
  localparam logic [63:0] WDT_CNT_RST = '1;

endpackage

// File: rtl/wdt_prescaler.sv
// Free-running tick divider for the watchdog; tick pulses once every 2**PRESCALE_LOG2 cycles.
module wdt_prescaler #(
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [PRESCALE_LOG2-1:0] div;

  // Clearing restarts a full period, so the first tick after clr is a whole period away.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = &div;

endmodule

// File: rtl/wdt_timeout_gen.sv
// Watchdog timer producing the registered WTO level for the CSR unit.
// Build option WDT_PRESCALE_EN enables the tick prescaler (otherwise tick every clk).
module wdt_timeout_gen
  import wdt_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_re,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        wto_ack,
  output logic        wto
);

  wdt_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] wtocnt;
  logic             wden;
  logic             wto_d;
  logic             tick;
  logic             wden_wr, wden_set, wden_clr, kick, wtocnt_wr;
  logic             unused_ok;

  assign wden_wr   = cfg_we && (cfg_addr == WDT_ADDR_WDEN);
  assign wden_set  = wden_wr && cfg_wdata[0];
  assign wden_clr  = wden_wr && !cfg_wdata[0];
  assign kick      = cfg_we && (cfg_addr == WDT_ADDR_WDLIVE) && cfg_wdata[0];
  assign wtocnt_wr = cfg_we && (cfg_addr == WDT_ADDR_WTOCNT) && !wden;

`ifdef WDT_PRESCALE_EN
  logic presc_clr;

  // Restart the tick period on entry to COUNT and on every accepted kick.
  assign presc_clr = ((state != WDT_COUNT) && (state_d == WDT_COUNT)) ||
                     ((state == WDT_COUNT) && kick);

  wdt_prescaler #(
    .PRESCALE_LOG2(PRESCALE_LOG2)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .tick(tick)
  );

  assign unused_ok = cfg_re;
`else
  assign tick      = 1'b1;
  assign unused_ok = cfg_re ^ PRESCALE_LOG2[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WDT_IDLE;
      cnt    <= '0;
      wto    <= 1'b0;
      wden   <= 1'b0;
      wtocnt <= WDT_CNT_RST[CNT_W-1:0];
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wto   <= wto_d;
      if (wden_wr) begin
        wden <= cfg_wdata[0];
      end
      if (wtocnt_wr) begin
        wtocnt <= cfg_wdata[CNT_W-1:0];
      end
    end
  end

  // Expiry holds cnt rather than incrementing, so an all-ones limit can never wrap it.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wto_d   = wto;
    case (state)
      WDT_IDLE: begin
        cnt_d = '0;
        wto_d = 1'b0;
        if (wden_set) begin
          state_d = WDT_COUNT;
        end
      end
      WDT_COUNT: begin
        if (kick) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt >= wtocnt) begin
            state_d = WDT_EXPIRED;
            wto_d   = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      WDT_EXPIRED: begin
        if (wto_ack) begin
          cnt_d   = '0;
          wto_d   = 1'b0;
          state_d = wden ? WDT_COUNT : WDT_IDLE;
        end
      end
      default: begin
        state_d = WDT_IDLE;
        cnt_d   = '0;
        wto_d   = 1'b0;
      end
    endcase
    if (wden_clr) begin
      state_d = WDT_IDLE;
      cnt_d   = '0;
      wto_d   = 1'b0;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      WDT_ADDR_WDEN:   cfg_rdata = {31'd0, wden};
      WDT_ADDR_WDLIVE: cfg_rdata = '0;
      WDT_ADDR_WTOCNT: cfg_rdata = 32'(wtocnt);
      WDT_ADDR_STATUS: cfg_rdata = {cnt[29:0], state};
      default:         cfg_rdata = '0;
    endcase
  end

endmodule
